// File: rtl/pwm_duty_ctrl.sv
// Button-driven duty-cycle controller with single-step and hold-to-repeat adjustment,
// feeding a PWM generator that only picks up a new duty at period boundaries.
module pwm_duty_ctrl #(
   parameter int unsigned PERIOD     = 100,
   parameter int unsigned STEP       = 10,
   parameter int unsigned INIT_DUTY  = 50,
   parameter int unsigned HOLD_DELAY = 25_000_000,
   parameter int unsigned REPEAT_INT = 5_000_000,
   localparam int unsigned DW        = $clog2(PERIOD + 1)
) (
   input  logic          clk,
   input  logic          sys_rst_n,
   input  logic          btn_up,
   input  logic          btn_down,
   input  logic          btn_mode,
   output logic          pwm_out,
   output logic [DW-1:0] duty,
   output logic [DW-1:0] duty_active,
   output logic          fine_mode,
   output logic          busy
);

   localparam int unsigned DW1  = DW + 1;
   localparam int unsigned TMAX = (HOLD_DELAY > REPEAT_INT) ? HOLD_DELAY : REPEAT_INT;
   localparam int unsigned TW   = $clog2(TMAX);

   localparam logic [DW-1:0] PERIOD_M1 = DW'(PERIOD - 1);
   localparam logic [DW-1:0] INIT_D    = DW'(INIT_DUTY);
   localparam logic [DW:0]   PERIOD_X  = DW1'(PERIOD);
   localparam logic [DW:0]   STEP_X    = DW1'(STEP);
   localparam logic [DW:0]   ONE_X     = DW1'(1);
   localparam logic [TW-1:0] HOLD_M1   = TW'(HOLD_DELAY - 1);
   localparam logic [TW-1:0] REP_M1    = TW'(REPEAT_INT - 1);

   typedef enum logic [1:0] {
      StIdle,
      StPress,
      StRepeat
   } state_e;

   state_e        state_q, state_d;
   logic          dir_q, dir_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [DW-1:0] duty_q, duty_d;
   logic [DW-1:0] duty_active_q;
   logic [DW-1:0] cnt_q, cnt_d;
   logic          pwm_q;
   logic          fine_q;
   logic          prev_up_q, prev_down_q, prev_mode_q;

   logic          rise_up, rise_down, rise_mode;
   logic          held;
   logic          step_en, step_dir;
   logic [DW:0]   step_size, sum_x, up_x, down_x;

   // ---------------------------------------------------------------------------------------------
   // Button edge detection and step-size toggle
   // ---------------------------------------------------------------------------------------------
   assign rise_up   = btn_up & ~prev_up_q;
   assign rise_down = btn_down & ~prev_down_q;
   assign rise_mode = btn_mode & ~prev_mode_q;

   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         prev_up_q   <= 1'b0;
         prev_down_q <= 1'b0;
         prev_mode_q <= 1'b0;
         fine_q      <= 1'b0;
      end else begin
         prev_up_q   <= btn_up;
         prev_down_q <= btn_down;
         prev_mode_q <= btn_mode;
         if (rise_mode) begin
            fine_q <= ~fine_q;
         end
      end
   end

   // ---------------------------------------------------------------------------------------------
   // Saturating step arithmetic, one bit wider than duty so nothing wraps
   // ---------------------------------------------------------------------------------------------
   assign step_size = fine_q ? ONE_X : STEP_X;
   assign sum_x     = {1'b0, duty_q} + step_size;
   assign up_x      = (sum_x > PERIOD_X) ? PERIOD_X : sum_x;
   assign down_x    = ({1'b0, duty_q} < step_size) ? '0 : ({1'b0, duty_q} - step_size);

   always_comb begin
      duty_d = duty_q;
      if (step_en) begin
         duty_d = step_dir ? DW'(down_x) : DW'(up_x);
      end
   end

   // ---------------------------------------------------------------------------------------------
   // Press / hold-to-repeat sequencer
   // ---------------------------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      dir_d    = dir_q;
      timer_d  = timer_q;
      step_en  = 1'b0;
      step_dir = dir_q;
      held     = dir_q ? btn_down : btn_up;

      unique case (state_q)
         StIdle: begin
            // Simultaneous rises are ambiguous and therefore dropped.
            if (rise_up ^ rise_down) begin
               step_en  = 1'b1;
               step_dir = rise_down;
               dir_d    = rise_down;
               timer_d  = '0;
               state_d  = StPress;
            end
         end
         StPress: begin
            if (!held) begin
               timer_d = '0;
               state_d = StIdle;
            end else if (timer_q == HOLD_M1) begin
               step_en = 1'b1;
               timer_d = '0;
               state_d = StRepeat;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         StRepeat: begin
            if (!held) begin
               timer_d = '0;
               state_d = StIdle;
            end else if (timer_q == REP_M1) begin
               step_en = 1'b1;
               timer_d = '0;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: begin
            timer_d = '0;
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q <= StIdle;
         dir_q   <= 1'b0;
         timer_q <= '0;
         duty_q  <= INIT_D;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         timer_q <= timer_d;
         duty_q  <= duty_d;
      end
   end

   // ---------------------------------------------------------------------------------------------
   // PWM generator; shadow duty is transferred only on the last count of a period
   // ---------------------------------------------------------------------------------------------
   assign cnt_d = (cnt_q == PERIOD_M1) ? '0 : cnt_q + 1'b1;

   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cnt_q         <= '0;
         duty_active_q <= INIT_D;
         pwm_q         <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         if (cnt_q == PERIOD_M1) begin
            duty_active_q <= duty_q;
         end
         pwm_q <= (cnt_q < duty_active_q);
      end
   end

   assign pwm_out     = pwm_q;
   assign duty        = duty_q;
   assign duty_active = duty_active_q;
   assign fine_mode   = fine_q;
   assign busy        = (state_q != StIdle);

endmodule

// File: doc/pwm_duty_ctrl.md
# pwm_duty_ctrl

Button-driven duty-cycle controller and PWM generator for the PWM lab datapath. It takes already-debounced up/down/mode buttons (outputs of the debounce stage), sequences single-step and hold-to-repeat duty adjustments, and applies the new duty glitch-free at PWM period boundaries. It drives the PWM pin directly and exposes the duty values for display.

## Interface
- PERIOD, default 100: PWM period in clk cycles (≥2).
- STEP, default 10: coarse duty step in counts (1 ≤ STEP ≤ PERIOD).
- INIT_DUTY, default 50: duty after reset (≤ PERIOD).
- HOLD_DELAY, default 25_000_000: cycles a button must stay held after its press step before auto-repeat starts (≥2).
- REPEAT_INT, default 5_000_000: cycles between auto-repeat steps (≥2).
- DW (derived, not overridable): $clog2(PERIOD+1).

Ports:
- clk  in  1  system clock; the only clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- btn_up  in  1  debounced, synchronous to clk; active high.
- btn_down  in  1  debounced, synchronous to clk; active high.
- btn_mode  in  1  debounced, synchronous to clk; active high; rising edge toggles step size.
- pwm_out  out  1  registered PWM output.
- duty  out  DW  pending (shadow) duty, 0..PERIOD.
- duty_active  out  DW  duty currently being generated.
- fine_mode  out  1  1 = step size 1, 0 = step size STEP.
- busy  out  1  high while FSM is not in IDLE.

## Operation
- Edge detect: prev_up/prev_down/prev_mode registers, reset to 0. Rise = btn & ~prev. A button held high across reset release therefore counts as a press on the first active cycle.
- Step size s = fine_mode ? 1 : STEP. Up: duty = min(duty + s, PERIOD). Down: duty = max(duty − s, 0). Compute in DW+1 bits; no wrap-around ever.
- fine_mode toggles on every rise of btn_mode, in any FSM state; takes effect for the next step.
- FSM states IDLE, PRESS, REPEAT; register dir (0 = up, 1 = down); timer counting 0..max(HOLD_DELAY, REPEAT_INT)−1.
  - IDLE: rise on exactly one of up/down → apply one step in that direction, latch dir, timer=0, go to PRESS. Both rising in the same cycle → ignored, stay in IDLE.
  - PRESS: dir button low → IDLE, no step. Else at timer == HOLD_DELAY−1 → one step, timer=0, go to REPEAT. Else timer+1.
  - REPEAT: dir button low → IDLE. Else at timer == REPEAT_INT−1 → one step, timer=0. Else timer+1.
  - The opposite button is ignored while in PRESS/REPEAT. A new press needs IDLE plus a fresh rise.
  - Steps at a saturated bound leave duty unchanged; the FSM still sequences normally.
- PWM: cnt counts 0..PERIOD−1 and wraps. When cnt == PERIOD−1, duty_active <= duty, so a duty change never takes effect mid-period.
- pwm_out <= (cnt < duty_active). duty 0 → constantly low; duty PERIOD → constantly high.

## Timing
- Reset values: cnt=0, duty=duty_active=INIT_DUTY, pwm_out=0, fine_mode=0, busy=0, state IDLE, timer=0, prev_*=0.
- Press latency: a btn rise sampled at edge t → duty updated after edge t; busy high from the next cycle.
- First repeat step comes HOLD_DELAY cycles after the press step; later steps every REPEAT_INT cycles.
- Release: dir low sampled at edge t → IDLE after edge t; a step due in that same cycle is suppressed.
- Duty applies at the next cnt == PERIOD−1 edge. pwm_out lags (cnt, duty_active) by one cycle; the first pwm_out of a new period reflects the new duty.
- If duty changes in the cycle where cnt == PERIOD−1, the pre-update duty is loaded (registered read).
- Reset asserted mid-operation: every register returns to its reset value immediately; no step is applied.

## Test plan
Bench parameters: PERIOD=10, STEP=3, INIT_DUTY=5, HOLD_DELAY=8, REPEAT_INT=4.
- Out of reset, no buttons → pwm_out high exactly 5 of every 10 cycles; duty=duty_active=5; busy=0.
- btn_up pulsed 3 cycles → duty 8, exactly one step. duty_active becomes 8 only after the next cnt=9 edge, then pwm_out high 8/10.
- btn_up held 30 cycles → steps at press, +8, +12, … with duty 8, 10, 10 (saturates at PERIOD); pwm_out constantly high once applied.
- btn_mode pulse, then btn_down held 20 cycles from duty 5 → fine_mode=1; duty 4, 3 (+8), 2 (+12), 1 (+16); release → IDLE, busy=0.
- btn_up and btn_down rise in the same cycle → duty unchanged, busy stays 0. Down held, then up pressed mid-hold → up ignored.
- sys_rst_n pulsed low during REPEAT with duty 2 → all outputs return to their reset values at once, with duty=5 and fine_mode=0.
